// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and physical memory.
// The arbiter connects through the slave modport; the cache and memory side
// uses the master modport.
interface cache_arbiter_if #(
    parameter int s_line = 256
);
    logic              i_read;
    logic [31:0]       i_addr;
    logic [s_line-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [31:0]       d_addr;
    logic [s_line-1:0] d_wdata;
    logic [s_line-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_addr;
    logic [s_line-1:0] pmem_wdata;
    logic [s_line-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical memory port between an
// instruction cache (read-only fills) and a data cache (fills and
// write-backs). One transaction is in flight at a time; memory commands are
// registered, completion strobes are combinational from pmem_resp.
module cache_arbiter #(
    parameter int s_line = 256
) (
    input  logic           clk,
    input  logic           reset,
    cache_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_grant;      // 0 = I won the last tie, 1 = D
    logic              w_last_grant_nxt;
    logic              r_pmem_read;
    logic              w_pmem_read_nxt;
    logic              r_pmem_write;
    logic              w_pmem_write_nxt;
    logic [31:0]       r_pmem_addr;
    logic [31:0]       w_pmem_addr_nxt;
    logic [s_line-1:0] r_pmem_wdata;
    logic [s_line-1:0] w_pmem_wdata_nxt;

    logic              w_i_pend;
    logic              w_d_pend;
    logic              w_tie;
    logic              w_grant_d;

    assign w_i_pend  = bus.i_read;
    assign w_d_pend  = bus.d_read | bus.d_write;
    assign w_tie     = w_i_pend & w_d_pend;
    // On a tie D wins unless D won the previous tie.
    assign w_grant_d = w_d_pend & (~w_i_pend | ~r_last_grant);

    // Next-state and next memory command; everything holds unless changed.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_pmem_read_nxt  = r_pmem_read;
        w_pmem_write_nxt = r_pmem_write;
        w_pmem_addr_nxt  = r_pmem_addr;
        w_pmem_wdata_nxt = r_pmem_wdata;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt      = SERVE_D;
                    w_pmem_addr_nxt  = bus.d_addr;
                    w_pmem_wdata_nxt = bus.d_wdata;
                    // A simultaneous read+write is treated as a write-back.
                    w_pmem_write_nxt = bus.d_write;
                    w_pmem_read_nxt  = ~bus.d_write;
                    if (w_tie) w_last_grant_nxt = 1'b1;
                end else if (w_i_pend) begin
                    w_state_nxt      = SERVE_I;
                    w_pmem_addr_nxt  = bus.i_addr;
                    w_pmem_read_nxt  = 1'b1;
                    w_pmem_write_nxt = 1'b0;
                    if (w_tie) w_last_grant_nxt = 1'b0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp) begin
                    w_state_nxt     = IDLE;
                    w_pmem_read_nxt  = 1'b0;
                    w_pmem_write_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt      = IDLE;
                w_pmem_read_nxt  = 1'b0;
                w_pmem_write_nxt = 1'b0;
            end
        endcase
    end

    // State, grant history and registered memory command.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_pmem_addr  <= '0;
            r_pmem_wdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_pmem_read  <= w_pmem_read_nxt;
            r_pmem_write <= w_pmem_write_nxt;
            r_pmem_addr  <= w_pmem_addr_nxt;
            r_pmem_wdata <= w_pmem_wdata_nxt;
        end
    end

    assign bus.pmem_read  = r_pmem_read;
    assign bus.pmem_write = r_pmem_write;
    assign bus.pmem_addr  = r_pmem_addr;
    assign bus.pmem_wdata = r_pmem_wdata;

    // Fill data is a plain pass-through; the strobes alone qualify it.
    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;
    assign bus.i_resp  = ~reset & (r_state == SERVE_I) & bus.pmem_resp;
    assign bus.d_resp  = ~reset & (r_state == SERVE_D) & bus.pmem_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single-requester fills and write-backs,
// round-robin ties, collisions, reset abort and read+write merging.
module tb_cache_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    localparam logic [255:0] LA5 = {32{8'hA5}};
    localparam logic [255:0] L5A = {32{8'h5A}};
    localparam logic [255:0] L33 = {32{8'h33}};
    localparam logic [255:0] LC3 = {32{8'hC3}};
    localparam logic [255:0] L00 = '0;
    localparam logic [255:0] L1  = 256'd1;

    cache_arbiter_if #(.s_line(256)) bus ();

    cache_arbiter #(.s_line(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.i_read = 1'b0; bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_pread",  {255'd0, bus.pmem_read},  L00);
        chk("rst_pwrite", {255'd0, bus.pmem_write}, L00);
        chk("rst_paddr",  {224'd0, bus.pmem_addr},  L00);
        chk("rst_pwdata", bus.pmem_wdata,           L00);
        chk("rst_iresp",  {255'd0, bus.i_resp},     L00);
        chk("rst_dresp",  {255'd0, bus.d_resp},     L00);

        // I-only fill
        cyc(); reset = 1'b0; bus.i_read = 1'b1; bus.i_addr = 32'h0000_1040; #1;
        chk("i1_pre_pread", {255'd0, bus.pmem_read}, L00);
        cyc(); #1;
        chk("i1_pread",  {255'd0, bus.pmem_read},  L1);
        chk("i1_pwrite", {255'd0, bus.pmem_write}, L00);
        chk("i1_paddr",  {224'd0, bus.pmem_addr},  256'h1040);
        cyc(); #1;
        chk("i1_hold_addr", {224'd0, bus.pmem_addr}, 256'h1040);
        chk("i1_wait_iresp", {255'd0, bus.i_resp}, L00);
        cyc(); bus.pmem_resp = 1'b1; bus.pmem_rdata = LA5; #1;
        chk("i1_iresp",  {255'd0, bus.i_resp}, L1);
        chk("i1_irdata", bus.i_rdata, LA5);
        chk("i1_dresp",  {255'd0, bus.d_resp}, L00);
        cyc(); bus.i_read = 1'b0; bus.pmem_resp = 1'b0; #1;
        chk("i1_done_iresp", {255'd0, bus.i_resp},    L00);
        chk("i1_done_pread", {255'd0, bus.pmem_read}, L00);

        // D write-back
        bus.d_write = 1'b1; bus.d_addr = 32'h2000_0020; bus.d_wdata = L5A;
        cyc(); #1;
        chk("d2_pwrite", {255'd0, bus.pmem_write}, L1);
        chk("d2_pread",  {255'd0, bus.pmem_read},  L00);
        chk("d2_paddr",  {224'd0, bus.pmem_addr},  256'h2000_0020);
        chk("d2_pwdata", bus.pmem_wdata, L5A);
        cyc(); bus.pmem_resp = 1'b1; bus.pmem_rdata = LC3; #1;
        chk("d2_dresp",  {255'd0, bus.d_resp}, L1);
        chk("d2_iresp",  {255'd0, bus.i_resp}, L00);
        chk("d2_drdata", bus.d_rdata, LC3);
        cyc(); bus.d_write = 1'b0; bus.pmem_resp = 1'b0; #1;
        chk("d2_done_pwrite", {255'd0, bus.pmem_write}, L00);

        // Tie after reset: D first, then I, then next tie goes to I
        reset = 1'b1;
        cyc(); reset = 1'b0;
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_3000;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_4000;
        cyc(); #1;
        chk("t3_paddr_d", {224'd0, bus.pmem_addr}, 256'h4000);
        chk("t3_pread_d", {255'd0, bus.pmem_read}, L1);
        cyc(); bus.pmem_resp = 1'b1; #1;
        chk("t3_dresp", {255'd0, bus.d_resp}, L1);
        chk("t3_iresp", {255'd0, bus.i_resp}, L00);
        cyc(); bus.d_read = 1'b0; bus.pmem_resp = 1'b0; #1;
        chk("t3_idle_pread", {255'd0, bus.pmem_read}, L00);
        cyc(); #1;
        chk("t3_paddr_i", {224'd0, bus.pmem_addr}, 256'h3000);
        chk("t3_pread_i", {255'd0, bus.pmem_read}, L1);
        cyc(); bus.pmem_resp = 1'b1; #1;
        chk("t3_iresp2", {255'd0, bus.i_resp}, L1);
        chk("t3_dresp2", {255'd0, bus.d_resp}, L00);
        cyc(); bus.pmem_resp = 1'b0;
        bus.i_addr = 32'h0000_5000;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_6000;
        cyc(); #1;
        chk("t3_tie2_paddr_i", {224'd0, bus.pmem_addr}, 256'h5000);
        cyc(); bus.pmem_resp = 1'b1; #1;
        chk("t3_tie2_iresp", {255'd0, bus.i_resp}, L1);
        chk("t3_tie2_dresp", {255'd0, bus.d_resp}, L00);
        cyc(); bus.i_read = 1'b0; bus.pmem_resp = 1'b0; #1;
        cyc(); #1;
        chk("t3_tie2_paddr_d", {224'd0, bus.pmem_addr}, 256'h6000);
        cyc(); bus.pmem_resp = 1'b1; #1;
        chk("t3_tie2_dresp2", {255'd0, bus.d_resp}, L1);
        cyc(); bus.d_read = 1'b0; bus.pmem_resp = 1'b0; #1;

        // Collision: D arrives while I waits on memory
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_7000;
        cyc(); bus.d_read = 1'b1; bus.d_addr = 32'h0000_8000; #1;
        chk("c4_paddr_i", {224'd0, bus.pmem_addr}, 256'h7000);
        cyc(); #1;
        chk("c4_hold_paddr", {224'd0, bus.pmem_addr}, 256'h7000);
        chk("c4_wait_dresp", {255'd0, bus.d_resp}, L00);
        cyc(); bus.pmem_resp = 1'b1; #1;
        chk("c4_iresp", {255'd0, bus.i_resp}, L1);
        chk("c4_dresp", {255'd0, bus.d_resp}, L00);
        cyc(); bus.i_read = 1'b0; bus.pmem_resp = 1'b0; #1;
        chk("c4_idle_pread", {255'd0, bus.pmem_read}, L00);
        cyc(); #1;
        chk("c4_paddr_d", {224'd0, bus.pmem_addr}, 256'h8000);
        chk("c4_pread_d", {255'd0, bus.pmem_read}, L1);

        // Reset during SERVE_D, memory would have answered two cycles later
        cyc(); reset = 1'b1; #1;
        chk("r5_dresp_in_rst", {255'd0, bus.d_resp}, L00);
        cyc(); reset = 1'b0; bus.d_read = 1'b0; #1;
        chk("r5_pread",  {255'd0, bus.pmem_read}, L00);
        chk("r5_paddr",  {224'd0, bus.pmem_addr}, L00);
        cyc(); bus.pmem_resp = 1'b1; #1;
        chk("r5_late_dresp", {255'd0, bus.d_resp}, L00);
        chk("r5_late_iresp", {255'd0, bus.i_resp}, L00);
        cyc(); bus.pmem_resp = 1'b0; #1;
        chk("r5_idle_pread", {255'd0, bus.pmem_read}, L00);

        // d_read and d_write together act as a write-back
        bus.d_read = 1'b1; bus.d_write = 1'b1;
        bus.d_addr = 32'h0000_9000; bus.d_wdata = L33;
        cyc(); #1;
        chk("w6_pwrite", {255'd0, bus.pmem_write}, L1);
        chk("w6_pread",  {255'd0, bus.pmem_read},  L00);
        chk("w6_pwdata", bus.pmem_wdata, L33);
        cyc(); bus.pmem_resp = 1'b1; #1;
        chk("w6_dresp", {255'd0, bus.d_resp}, L1);
        cyc(); bus.d_read = 1'b0; bus.d_write = 1'b0; bus.pmem_resp = 1'b0; #1;
        chk("w6_done_pwrite", {255'd0, bus.pmem_write}, L00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: s_line, default 256, width in bits of one cache line and of every line-data port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_read  input  1  instruction-cache line-fill request, held high until i_resp.
REQ-005 i_addr  input  32  instruction-cache line address, bits [4:0] zero.
REQ-006 i_rdata  output  s_line  fill data returned to the instruction cache.
REQ-007 i_resp  output  1  one-cycle completion strobe to the instruction cache.
REQ-008 d_read  input  1  data-cache line-fill request, held high until d_resp.
REQ-009 d_write  input  1  data-cache write-back request, held high until d_resp.
REQ-010 d_addr  input  32  data-cache line address, bits [4:0] zero.
REQ-011 d_wdata  input  s_line  write-back line from the data cache.
REQ-012 d_rdata  output  s_line  fill data returned to the data cache.
REQ-013 d_resp  output  1  one-cycle completion strobe to the data cache.
REQ-014 pmem_read  output  1  registered read command to physical memory.
REQ-015 pmem_write  output  1  registered write command to physical memory.
REQ-016 pmem_addr  output  32  registered physical memory line address.
REQ-017 pmem_wdata  output  s_line  registered physical memory write line.
REQ-018 pmem_rdata  input  s_line  physical memory read line.
REQ-019 pmem_resp  input  1  physical memory completion strobe.

Function
REQ-020 States: IDLE, SERVE_I, SERVE_D; the arbiter also holds a 1-bit last_grant register (0 = I, 1 = D).
REQ-021 IDLE, only I pending: next state SERVE_I; latch i_addr, pmem_read=1, pmem_write=0.
REQ-022 IDLE, only D pending (d_read or d_write): next state SERVE_D; latch d_addr and d_wdata, pmem_write=d_write, pmem_read=~d_write.
REQ-023 d_read and d_write both high: the request is treated as a write.
REQ-024 IDLE, both I and D pending: grant the requester not equal to last_grant (round-robin); update last_grant to the granted side at the grant edge.
REQ-025 Grant latency: pmem command, address and data are valid the first cycle after the request is seen in IDLE, and stay stable until pmem_resp.
REQ-026 SERVE_x with pmem_resp=1: assert x_resp combinationally in that same cycle, with x_rdata=pmem_rdata; at the next edge go to IDLE and clear pmem_read and pmem_write.
REQ-027 SERVE_x with pmem_resp=0: hold the state and all pmem outputs; never assert any resp.
REQ-028 A request arriving during SERVE of the other side waits; it is arbitrated in IDLE after completion, with a minimum of one IDLE cycle between transactions.
REQ-029 i_resp and d_resp are never high in the same cycle; no resp is ever asserted in IDLE.
REQ-030 i_rdata and d_rdata pass pmem_rdata through at all times; only the resp strobes qualify them.
REQ-031 pmem_resp seen in IDLE is ignored.

Reset
REQ-032 reset=1 at an edge: state becomes IDLE, pmem_read=0, pmem_write=0, pmem_addr=0, pmem_wdata=0, last_grant=0 (so D wins the first tie); i_resp=d_resp=0 during reset.
REQ-033 Reset mid-transaction aborts it without a resp; pmem commands drop the next cycle; requests sampled while reset=1 are ignored.

Verification
REQ-034 I-only: i_read=1, i_addr=0x0000_1040; memory responds 3 cycles later with line 0xA5.. -> pmem_read=1 and pmem_addr=0x1040 from the next cycle; i_resp=1 for one cycle with i_rdata=0xA5..; d_resp stays 0.
REQ-035 D write-back: d_write=1, d_addr=0x2000_0020, d_wdata=0x5A.. -> pmem_write=1, pmem_read=0, pmem_wdata=0x5A..; d_resp on pmem_resp; then IDLE.
REQ-036 Tie after reset: i_read and d_read rise together -> D served first (pmem_addr=d_addr); I served next after one IDLE cycle; the following tie goes to I.
REQ-037 Collision: d_read rises while SERVE_I waits on memory -> pmem_addr stays i_addr; after i_resp, SERVE_D starts; no overlapping resp.
REQ-038 Reset during SERVE_D, two cycles before pmem_resp -> no d_resp; pmem_read=0 next cycle; the late pmem_resp is ignored in IDLE.
REQ-039 d_read=d_write=1 -> pmem_write=1, pmem_read=0.
